// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave controller: state encoding and address helpers.
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_RX        = 3'd3,
        S_RX_ACK    = 3'd4,
        S_TX        = 3'd5,
        S_TX_ACK    = 3'd6,
        S_WAIT_STOP = 3'd7
    } state_e;

    localparam logic [6:0] DEFAULT_ADDR = 7'h50;

    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] addr);
        return addr_byte[7:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Pad synchroniser plus registered rise/fall strobes; level_o is aligned with the strobes.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iclk,
    input  logic reset,
    input  logic pad_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would collapse the chain.
    always_ff @(posedge iclk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// Byte-level I2C slave: START/STOP detection, address match, RX/TX shifting and ACK driving,
// all from synchronous strobes on iclk.
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       iclk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       addr_hit,
    output logic       rw,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .iclk    (iclk),
        .reset   (reset),
        .pad_i   (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .iclk    (iclk),
        .reset   (reset),
        .pad_i   (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       addr_hit_q, addr_hit_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       load_q, load_d;
    // phase_q: ACK already driven in ADDR_ACK, byte complete in RX, first bit pending in TX.
    logic       phase_q, phase_d;
    logic [7:0] byte_in;

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        sda_oe_d   = sda_oe_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        phase_d    = phase_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        addr_hit_d = 1'b0;
        load_d     = 1'b0;
        byte_in    = {shift_q[6:0], sda_lvl};

        if (load_q) begin
            shift_d = tx_data;
        end

        if (sda_fall && scl_lvl) begin
            state_d  = S_ADDR;
            cnt_d    = 3'd0;
            busy_d   = 1'b1;
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
        end else if (sda_rise && scl_lvl) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (addr_match(byte_in, ADDR)) begin
                                addr_hit_d = 1'b1;
                                rw_d       = sda_lvl;
                                phase_d    = 1'b0;
                                state_d    = S_ADDR_ACK;
                            end else begin
                                state_d = S_WAIT_STOP;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                            tx_req_d = rw_q;
                            load_d   = rw_q;
                        end else if (rw_q) begin
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                            cnt_d    = 3'd1;
                            phase_d  = 1'b0;
                            state_d  = S_TX;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 3'd0;
                            phase_d  = 1'b0;
                            state_d  = S_RX;
                        end
                    end
                end
                S_RX: begin
                    if (scl_rise && !phase_q) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            phase_d    = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b0;
                        state_d  = S_RX_ACK;
                    end
                end
                S_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 3'd0;
                        state_d  = S_RX;
                    end
                end
                S_TX: begin
                    // Counter wraps to 0 after the 8th driven bit; that fall opens the ACK slot.
                    if (scl_fall) begin
                        if (phase_q || cnt_q != 3'd0) begin
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                            cnt_d    = cnt_q + 3'd1;
                            phase_d  = 1'b0;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = S_TX_ACK;
                        end
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise) begin
                        if (!sda_lvl) begin
                            tx_req_d = 1'b1;
                            load_d   = 1'b1;
                            phase_d  = 1'b1;
                            state_d  = S_TX;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                S_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iclk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            addr_hit_q <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            load_q     <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            sda_oe_q   <= sda_oe_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            addr_hit_q <= addr_hit_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            load_q     <= load_d;
            phase_q    <= phase_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign addr_hit = addr_hit_q;
    assign rw       = rw_q;
    assign busy     = busy_q;

endmodule
